// File: rtl/gost34_12_2015_pkg.sv
// rtl/gost34_12_2015_pkg.sv - shared types, constants and key-schedule helper for the Magma core
package gost34_12_2015_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GOST_ROUNDS = 32;

  // id-tc26-gost-28147-param-Z; each 64-bit row is one nibble's table, entry 0 in the top 4 bits
  localparam logic [511:0] SBOX_TC26_Z = {
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  // Encrypt walks K1..K8 three times then K8..K1; decrypt is the mirror image.
  function automatic logic [2:0] key_idx(input logic [4:0] rnd, input logic decrypt);
    logic fwd;
    fwd = decrypt ? (rnd < 5'd8) : (rnd < 5'd24);
    return fwd ? rnd[2:0] : ~rnd[2:0];
  endfunction

endpackage

// File: rtl/gost34_12_2015_round.sv
// rtl/gost34_12_2015_round.sv - one combinational Magma round: add key, substitute, rotate, xor
module gost34_12_2015_round (
  input  logic         aclk,
  input  logic [31:0]  key,
  input  logic [31:0]  n1,
  input  logic [31:0]  n2,
  input  logic [511:0] sbox,
  output logic [31:0]  out1,
  output logic [31:0]  out2
);

  logic        unused_aclk;
  logic [31:0] sum;
  logic [31:0] sub;
  logic [63:0] row;
  logic [5:0]  pos;

  assign unused_aclk = aclk;
  assign sum = n1 + key;

  always_comb begin
    sub = '0;
    row = '0;
    pos = '0;
    for (int i = 0; i < 8; i++) begin
      row = sbox[511 - 64*i -: 64];
      pos = 6'd63 - {sum[4*i +: 4], 2'b00};
      sub[4*i +: 4] = row[pos -: 4];
    end
  end

  assign out1 = n2 ^ {sub[20:0], sub[31:21]};
  assign out2 = n1;

endmodule

// File: rtl/gost34_12_2015_magma_iter.sv
// rtl/gost34_12_2015_magma_iter.sv - iterative Magma encrypt/decrypt, one round per clock
module gost34_12_2015_magma_iter
  import gost34_12_2015_pkg::*;
(
  input  logic         aclk,
  input  logic         areset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_decrypt,
  input  logic [255:0] s_key,
  input  logic [63:0]  s_data,
  input  logic [511:0] sbox,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [63:0]  m_data,
  output logic         busy
);

  state_t         state;
  state_t         state_nx;
  logic [4:0]     rnd;
  logic [31:0]    n1;
  logic [31:0]    n2;
  logic [255:0]   key_q;
  logic [511:0]   sbox_q;
  logic           dec_q;
  logic [2:0]     idx;
  logic [31:0]    rk;
  logic [31:0]    out1;
  logic [31:0]    out2;
  logic           accept;
  logic           last;

  assign s_ready = (state == IDLE) || ((state == DONE) && m_ready);
  assign accept  = s_valid && s_ready;
  assign last    = (rnd == 5'(GOST_ROUNDS - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (m_ready) state_nx = s_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rnd     <= '0;
      n1      <= '0;
      n2      <= '0;
      key_q   <= '0;
      sbox_q  <= '0;
      dec_q   <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (accept) begin
        n1     <= s_data[31:0];
        n2     <= s_data[63:32];
        key_q  <= s_key;
        sbox_q <= sbox;
        dec_q  <= s_decrypt;
        rnd    <= '0;
      end else if (state == RUN) begin
        if (last) begin
          // final round keeps the halves in place (no swap)
          m_data <= {out1, out2};
        end else begin
          n1  <= out1;
          n2  <= out2;
          rnd <= rnd + 5'd1;
        end
      end

      if ((state == RUN) && last) begin
        m_valid <= 1'b1;
      end else if ((state == DONE) && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign idx = key_idx(rnd, dec_q);

  always_comb begin
    rk = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx == 3'(i)) rk = key_q[255 - 32*i -: 32];
    end
  end

  gost34_12_2015_round u_round (
    .aclk (aclk),
    .key  (rk),
    .n1   (n1),
    .n2   (n2),
    .sbox (sbox_q),
    .out1 (out1),
    .out2 (out2)
  );

endmodule
